fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Sole owner of the framebuffer RAM write port (`wraddress`/`data`/`wren`, clocked by CLOCK_50). It shares that port between two player trail writers and a built-in clear engine. The clear engine wipes all 640×480 words on game restart. The block sits between the jogador instances and the dual-port `ram`. The read port (VGA side) is untouched.

## Interface
Parameters:
- `FB_WORDS`, 307200: framebuffer depth (640×480).
- `ADDR_W`, 19: address width.
- `DATA_W`, 8: word width.
- `CLEAR_VALUE`, 8'h00: word written by the clear engine.

Ports:
- `CLOCK_50`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `clear_start`  in  1  request a full clear. Sampled every cycle.
- `clear_busy`  out  1  high while in S_CLEAR.
- `clear_done`  out  1  one-cycle pulse after the final clear write.
- `p1_req`  in  1  player 1 write request.
- `p1_addr`  in  ADDR_W  player 1 address.
- `p1_data`  in  DATA_W  player 1 data.
- `p1_ack`  out  1  player 1 accepted (combinational).
- `p2_req`, `p2_addr`, `p2_data`, `p2_ack`: same as player 1, for player 2.
- `wr_addr`  out  ADDR_W  to `ram.wraddress`.
- `wr_data`  out  DATA_W  to `ram.data`.
- `wren`  out  1  to `ram.wren`.
- `oob_err`  out  1  sticky flag: a player address was ≥ FB_WORDS.

## Operation
- States:
  - S_RUN: serve players.
  - S_CLEAR: sweep the framebuffer.
- S_RUN → S_CLEAR when `clear_start`=1. Clear has absolute priority over players.
- S_CLEAR → S_RUN after the write at address FB_WORDS-1.
- Handshake: valid/ready. A transfer occurs on the edge where `pX_req`&`pX_ack`=1.
  - The requester holds addr/data stable while req=1 and ack=0.
  - The requester may present a new request in the cycle after acceptance.
  - Back-to-back transfers are allowed, one per cycle total.
- `pX_ack` is 1 only in S_RUN, with `clear_start`=0, `pX_req`=1, and X winning arbitration.
- Arbitration is round-robin on contention.
  - The pointer `last` records the last granted player and updates on every grant.
  - If both request, the player ≠ `last` wins.
  - A single requester always wins.
- Out-of-range address (≥ FB_WORDS): the request is still acked and consumed, but no write is issued (`wren`=0). `oob_err` is set and stays set until reset.
- Clear sweep:
  - A counter of ceil(log2 FB_WORDS) bits, ≤ ADDR_W, starts at 0.
  - One write per cycle: `wr_addr`=counter, `wr_data`=CLEAR_VALUE.
  - The counter increments by 1 and does not wrap. It exits at FB_WORDS-1.
- `clear_start` during S_CLEAR restarts the sweep at address 0. `clear_done` fires only once, at the true end.
- Reset mid-clear: the clear aborts, the state returns to S_RUN, and no `clear_done` is issued.

## Timing
- Reset values:
  - state = S_RUN, `last` = P2 (P1 wins first contention).
  - `wren`=0, `wr_addr`=0, `wr_data`=0.
  - `clear_busy`=0, `clear_done`=0, `oob_err`=0, counter=0.
- Write outputs are registered. For a transfer at edge N, `wren`/`wr_addr`/`wr_data` are valid in the cycle after edge N and last exactly one cycle.
- `clear_start` sampled at edge N:
  - `clear_busy`=1 from edge N+1.
  - The first clear write (addr 0) is presented from edge N+1.
  - The last write (FB_WORDS-1) is presented from edge N+FB_WORDS.
  - `clear_done`=1 and `clear_busy`=0 from edge N+FB_WORDS+1, for one cycle.
  - Total time is 6.144 ms at 50 MHz.
- Simultaneous `clear_start` and a player request: the player is not acked, and the request remains pending.
- `wren` is 0 in any cycle with no granted in-range write.

## Configuration
- `FB_ARB_CLEAR_EN` defined: the clear engine and S_CLEAR are compiled in, as described above.
- `FB_ARB_CLEAR_EN` undefined:
  - The state machine is reduced to S_RUN only.
  - `clear_start` is ignored.
  - `clear_busy`=0 and `clear_done`=0 permanently.
  - The counter is removed.
  - Player arbitration is unchanged.

## Structure
- Package `fb_pkg` holds:
  - FB_W=640, FB_H=480, FB_WORDS.
  - ADDR_W, DATA_W.
  - Trail codes: EMPTY=8'h00, P1_TRAIL=8'h01, P2_TRAIL=8'h02.
  - State enum {S_RUN, S_CLEAR}.
  - Player-id enum {P1, P2}.
- One sub-module, `rr_arb2`: a 2-input round-robin arbiter holding the `last` pointer. Inputs are req[1:0] and enable; outputs are a one-hot grant.

## Test plan
1. Reset, then `p1_req`=1 with addr=1000 and data=8'h01 → `p1_ack`=1 the same cycle; next cycle `wren`=1, `wr_addr`=1000, `wr_data`=8'h01.
2. Both players request continuously for 4 cycles → grants go P1, P2, P1, P2; 4 consecutive `wren` pulses.
3. Pulse `clear_start` once → `clear_busy` stays high for 307200 cycles; `wr_addr` goes 0…307199 with data 0; `clear_done` pulses once; no player acks during the sweep.
4. `p2_req` held high during a clear → `p2_ack`=0 until `clear_busy` falls; the write is issued right after the clear ends.
5. Assert `reset` at sweep address 5000 → `wren`=0 next cycle; `clear_busy`=0; no `clear_done`.
6. `p1_addr`=307200 → acked; `wren`=0; `oob_err`=1 and stays set until reset.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the framebuffer write path.
//   - Framebuffer geometry (640x480) and the address/data widths of the RAM port.
//   - Trail codes written into the framebuffer by the players and the clear engine.
//   - Arbiter state encoding and the player identifier used by the round-robin pointer.
// No ports: this file is a package only.
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W     = 640;
    localparam int FB_H     = 480;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;

    localparam logic [7:0] EMPTY    = 8'h00;
    localparam logic [7:0] P1_TRAIL = 8'h01;
    localparam logic [7:0] P2_TRAIL = 8'h02;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } fb_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_id_t;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The grant is combinational; the pointer of the
// last granted player is registered and moves on every grant.
// With both inputs requesting, the player that was not granted last wins. A
// single requester always wins. No grant is issued while enable is low.
// Ports:
//   CLOCK_50  in   clock, rising edge
//   reset     in   synchronous, active-high; pointer returns to P2 so that
//                  P1 wins the first contention
//   req[1:0]  in   req[0] = player 1, req[1] = player 2
//   enable    in   arbitration allowed this cycle
//   grant[1:0] out one-hot (or zero) grant, same bit order as req
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);
    import fb_pkg::*;

    player_id_t last_reg;
    player_id_t last_next;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = (last_reg == P1) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_comb begin
        last_next = last_reg;
        if (grant[0]) begin
            last_next = P1;
        end else if (grant[1]) begin
            last_next = P2;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_reg <= P2;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
// Sole owner of the framebuffer RAM write port. Shares it between two player
// trail writers (valid/ready handshake, round-robin on contention) and a clear
// engine that sweeps every word to CLEAR_VALUE on game restart.
//
// Build option: define FB_ARB_CLEAR_EN to compile in the clear engine and the
// S_CLEAR state. Without it the block only arbitrates players, clear_start is
// ignored and clear_busy/clear_done stay low.
//
// Ports:
//   CLOCK_50            in   clock, rising edge
//   reset               in   synchronous, active-high
//   clear_start         in   request a full clear (restarts a running sweep)
//   clear_busy          out  high while sweeping
//   clear_done          out  one-cycle pulse after the final clear write
//   p1_req/addr/data    in   player 1 write request
//   p1_ack              out  player 1 accepted this cycle (combinational)
//   p2_req/addr/data    in   player 2 write request
//   p2_ack              out  player 2 accepted this cycle (combinational)
//   wr_addr/wr_data     out  registered RAM write address/data
//   wren                out  registered RAM write enable (one cycle per write)
//   oob_err             out  sticky: a player address was >= FB_WORDS
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int                FB_WORDS    = fb_pkg::FB_WORDS,
    parameter int                ADDR_W      = fb_pkg::ADDR_W,
    parameter int                DATA_W      = fb_pkg::DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = fb_pkg::EMPTY
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ack,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_data,
    output logic              p2_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic              oob_err
);
    import fb_pkg::*;

    // One extra bit so FB_WORDS itself is representable when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(FB_WORDS);

    logic [1:0]        grant;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_in_range;

    logic              wren_reg,    wren_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              oob_reg,     oob_next;

    rr_arb2 u_arb (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .req      ({p2_req, p1_req}),
        .enable   (arb_en),
        .grant    (grant)
    );

    assign p1_ack       = grant[0];
    assign p2_ack       = grant[1];
    assign sel_addr     = grant[1] ? p2_addr : p1_addr;
    assign sel_data     = grant[1] ? p2_data : p1_data;
    assign sel_in_range = ({1'b0, sel_addr} < ADDR_LIMIT);

`ifdef FB_ARB_CLEAR_EN
    localparam int            CW       = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FB_WORDS - 1);

    fb_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic          done_reg,  done_next;
    logic          cnt_at_last;

    // cnt_reg holds the address currently presented on wr_addr during a sweep.
    assign cnt_at_last = (cnt_reg == CNT_LAST);

    // Clear owns the port outright: a pending clear_start blocks players even
    // in the cycle it is first seen.
    assign arb_en     = (state_reg == S_RUN) && !clear_start;
    assign clear_busy = (state_reg == S_CLEAR);
    assign clear_done = done_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg <= S_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RUN: begin
                if (clear_start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!clear_start && cnt_at_last) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end
`else
    assign arb_en     = 1'b1;
    assign clear_busy = 1'b0;
    assign clear_done = 1'b0;

    logic unused_clear;
    assign unused_clear = clear_start ^ (|CLEAR_VALUE);
`endif

    // Next values of the registered write port and status flags.
    always_comb begin
        wren_next    = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        oob_next     = oob_reg;

        // Out-of-range requests are still consumed, only the write is dropped.
        if (grant != 2'b00) begin
            if (sel_in_range) begin
                wren_next    = 1'b1;
                wr_addr_next = sel_addr;
                wr_data_next = sel_data;
            end else begin
                oob_next = 1'b1;
            end
        end

`ifdef FB_ARB_CLEAR_EN
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        // grant is zero whenever either branch below is taken.
        if (clear_start) begin
            cnt_next     = '0;
            wren_next    = 1'b1;
            wr_addr_next = '0;
            wr_data_next = CLEAR_VALUE;
        end else if (state_reg == S_CLEAR) begin
            if (cnt_at_last) begin
                done_next = 1'b1;
            end else begin
                cnt_next     = cnt_reg + 1'b1;
                wren_next    = 1'b1;
                wr_addr_next = ADDR_W'(cnt_next);
                wr_data_next = CLEAR_VALUE;
            end
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wren_reg    <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            oob_reg     <= 1'b0;
`ifdef FB_ARB_CLEAR_EN
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
`endif
        end else begin
            wren_reg    <= wren_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
            oob_reg     <= oob_next;
`ifdef FB_ARB_CLEAR_EN
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
`endif
        end
    end

    assign wren    = wren_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign oob_err = oob_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
// Randomised plus directed stimulus for fb_write_arbiter. Each cycle the
// driver applies inputs, checks the combinational acks against a behavioural
// model and queues the outputs expected after the coming edge; a monitor pops
// one expectation per cycle and compares it with the registered outputs.
// A reduced framebuffer depth keeps full clear sweeps short. Works with and
// without FB_ARB_CLEAR_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_write_arbiter;

    localparam int             FBW     = 6000;
    localparam int             AW      = 19;
    localparam int             DW      = 8;
    localparam logic [DW-1:0]  CLR_VAL = 8'h5A;
`ifdef FB_ARB_CLEAR_EN
    localparam bit             CLR_EN  = 1'b1;
`else
    localparam bit             CLR_EN  = 1'b0;
`endif

    typedef struct {
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
        logic          oob;
        logic          chk_ad;
    } rec_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic          p1_req;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;
    logic          p1_ack;
    logic          p2_req;
    logic [AW-1:0] p2_addr;
    logic [DW-1:0] p2_data;
    logic          p2_ack;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wren;
    logic          oob_err;

    fb_write_arbiter #(
        .FB_WORDS    (FBW),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .CLEAR_VALUE (CLR_VAL)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .p1_req      (p1_req),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .p1_ack      (p1_ack),
        .p2_req      (p2_req),
        .p2_addr     (p2_addr),
        .p2_data     (p2_data),
        .p2_ack      (p2_ack),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wren        (wren),
        .oob_err     (oob_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;
    rec_t sb[$];
    rec_t mon_rec;

    // Behavioural model state.
    int   m_sweep = -1;   // address presented by the sweep, -1 when idle
    int   m_last  = 2;    // last granted player (1 or 2)
    bit   m_oob   = 1'b0;

    // Staged player stimulus and handshake hold flags.
    logic          st_r1 = 1'b0, st_r2 = 1'b0;
    logic [AW-1:0] st_a1 = '0,   st_a2 = '0;
    logic [DW-1:0] st_d1 = '0,   st_d2 = '0;
    bit            pend1 = 1'b0, pend2 = 1'b0;

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) begin
            return AW'($urandom_range(FBW, (1 << AW) - 1));
        end
        return AW'($urandom_range(0, FBW - 1));
    endfunction

    // mode 0: random requests, 1: both request, 2: no new requests.
    // A request that was not accepted is held unchanged.
    task automatic players(input int mode);
        if (!pend1) begin
            st_r1 = (mode == 1) ? 1'b1 : (mode == 0) ? ($urandom_range(0, 9) < 7) : 1'b0;
            st_a1 = rand_addr();
            st_d1 = DW'($urandom);
        end
        if (!pend2) begin
            st_r2 = (mode == 1) ? 1'b1 : (mode == 0) ? ($urandom_range(0, 9) < 7) : 1'b0;
            st_a2 = rand_addr();
            st_d2 = DW'($urandom);
        end
    endtask

    task automatic tick(input bit rst, input bit cs);
        rec_t          rec;
        bit            g1, g2, en;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge CLOCK_50);
        reset       = rst;
        clear_start = cs;
        p1_req      = rst ? 1'b0 : st_r1;
        p1_addr     = st_a1;
        p1_data     = st_d1;
        p2_req      = rst ? 1'b0 : st_r2;
        p2_addr     = st_a2;
        p2_data     = st_d2;
        #1;
        rec.wren = 1'b0; rec.addr = '0; rec.data = '0;
        rec.busy = 1'b0; rec.done = 1'b0; rec.oob = 1'b0; rec.chk_ad = 1'b0;
        if (rst) begin
            m_sweep    = -1;
            m_last     = 2;
            m_oob      = 1'b0;
            pend1      = 1'b0;
            pend2      = 1'b0;
            rec.chk_ad = 1'b1;
        end else begin
            en = (m_sweep < 0) && !(CLR_EN && cs);
            g1 = 1'b0;
            g2 = 1'b0;
            if (en) begin
                if (p1_req && p2_req) begin
                    if (m_last == 2) g1 = 1'b1;
                    else             g2 = 1'b1;
                end else begin
                    g1 = p1_req;
                    g2 = p2_req;
                end
            end
            total++;
            if (p1_ack !== g1 || p2_ack !== g2) begin
                bad++;
                $display("FAIL ack cycle %0d: got p1_ack=%b p2_ack=%b, required p1_ack=%b p2_ack=%b",
                         ncyc, p1_ack, p2_ack, g1, g2);
            end
            pend1 = p1_req && !g1;
            pend2 = p2_req && !g2;
            if (CLR_EN && cs) begin
                m_sweep  = 0;
                rec.wren = 1'b1;
                rec.addr = '0;
                rec.data = CLR_VAL;
            end else if (m_sweep >= 0) begin
                if (m_sweep == FBW - 1) begin
                    m_sweep  = -1;
                    rec.done = 1'b1;
                end else begin
                    m_sweep  = m_sweep + 1;
                    rec.wren = 1'b1;
                    rec.addr = AW'(m_sweep);
                    rec.data = CLR_VAL;
                end
            end else if (g1 || g2) begin
                m_last = g1 ? 1 : 2;
                a      = g1 ? p1_addr : p2_addr;
                d      = g1 ? p1_data : p2_data;
                if (int'(a) < FBW) begin
                    rec.wren = 1'b1;
                    rec.addr = a;
                    rec.data = d;
                end else begin
                    m_oob = 1'b1;
                end
            end
            rec.busy = (m_sweep >= 0);
            rec.oob  = m_oob;
        end
        sb.push_back(rec);
        ncyc++;
    endtask

    // One expectation per cycle, compared against the registered outputs.
    always @(negedge CLOCK_50) begin
        if (sb.size() > 0) begin
            mon_rec = sb.pop_front();
            total++;
            if (wren !== mon_rec.wren || clear_busy !== mon_rec.busy ||
                clear_done !== mon_rec.done || oob_err !== mon_rec.oob ||
                ((mon_rec.wren || mon_rec.chk_ad) &&
                 (wr_addr !== mon_rec.addr || wr_data !== mon_rec.data))) begin
                bad++;
                $display("FAIL outputs cycle %0d: got wren=%b addr=%0d data=%h busy=%b done=%b oob=%b, required wren=%b addr=%0d data=%h busy=%b done=%b oob=%b",
                         ncyc, wren, wr_addr, wr_data, clear_busy, clear_done, oob_err,
                         mon_rec.wren, mon_rec.addr, mon_rec.data, mon_rec.busy,
                         mon_rec.done, mon_rec.oob);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        p1_req      = 1'b0;
        p1_addr     = '0;
        p1_data     = '0;
        p2_req      = 1'b0;
        p2_addr     = '0;
        p2_data     = '0;

        repeat (3) tick(1'b1, 1'b0);

        // Single player 1 write.
        st_r1 = 1'b1; st_a1 = AW'(1000); st_d1 = 8'h01; st_r2 = 1'b0;
        tick(1'b0, 1'b0);
        st_r1 = 1'b0;
        tick(1'b0, 1'b0);

        // Fresh pointer, continuous contention.
        tick(1'b1, 1'b0);
        repeat (4) begin players(1); tick(1'b0, 1'b0); end
        repeat (3) begin players(2); tick(1'b0, 1'b0); end

        // Random traffic including out-of-range addresses.
        repeat (400) begin players(0); tick(1'b0, 1'b0); end
        repeat (3) begin players(2); tick(1'b0, 1'b0); end

        // Full clear with player 2 waiting and a restart partway through.
        st_r1 = 1'b0; st_r2 = 1'b1; st_a2 = AW'(777); st_d2 = 8'h02;
        tick(1'b0, 1'b1);
        for (int i = 0; i < FBW + 150; i++) begin
            players(2);
            tick(1'b0, (i == 100));
        end
        repeat (50) begin players(0); tick(1'b0, 1'b0); end
        repeat (3) begin players(2); tick(1'b0, 1'b0); end

        // Reset in the middle of a sweep.
        tick(1'b0, 1'b1);
        for (int i = 0; i < FBW && m_sweep != 5000; i++) begin
            players(0);
            tick(1'b0, 1'b0);
        end
        tick(1'b1, 1'b0);
        repeat (5) begin players(2); tick(1'b0, 1'b0); end
        repeat (3) begin players(2); tick(1'b0, 1'b0); end

        // Out-of-range addresses: acked, no write, sticky flag until reset.
        st_r1 = 1'b1; st_a1 = AW'(307200); st_d1 = 8'h01; st_r2 = 1'b0;
        tick(1'b0, 1'b0);
        st_a1 = AW'(FBW);
        tick(1'b0, 1'b0);
        st_r1 = 1'b0; pend1 = 1'b0; pend2 = 1'b0;
        repeat (20) begin players(0); tick(1'b0, 1'b0); end
        tick(1'b1, 1'b0);
        repeat (5) begin players(2); tick(1'b0, 1'b0); end

        @(negedge CLOCK_50);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
